// File: rtl/mouse_transmitter.sv
// PS/2 host-to-mouse byte transmitter.
// Inhibits the clock, issues a request-to-send, shifts out 8 data bits, parity and stop, checks the ACK.
module mouse_transmitter #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  input  logic       DATA_MOUSE_IN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       ERROR
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ACK,
    S_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q;
  logic          par_q;
  logic          load;
  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;
  logic          sent_q, sent_d;
  logic          err_q, err_d;
  logic          fall;
  logic          timeout;

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = (state_q != S_IDLE) && (state_q != S_INHIBIT) &&
                   (cnt_q == TO_LIM);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      clk_meta_q <= CLK_MOUSE_IN;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= DATA_MOUSE_IN;
      dat_sync_q <= dat_meta_q;
      sent_q     <= sent_d;
      err_q      <= err_d;
      if (state_q == S_IDLE || state_d != state_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (load) begin
        byte_q <= BYTE_TO_SEND;
        par_q  <= ~(^BYTE_TO_SEND);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sent_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (SEND_BYTE) begin
          load    = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) state_d = S_REQUEST;
      end
      S_REQUEST: begin
        if (fall) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          if (bit_q == 3'd7) state_d = S_PARITY;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        if (fall) begin
          if (dat_sync_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (clk_sync_q && dat_sync_q) begin
          sent_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A stuck bus overrides whatever the state wanted to do.
    if (timeout) begin
      state_d = S_IDLE;
      sent_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    CLK_MOUSE_OUT_EN  = 1'b0;
    DATA_MOUSE_OUT_EN = 1'b0;
    DATA_MOUSE_OUT    = 1'b1;
    unique case (state_q)
      S_INHIBIT: begin
        CLK_MOUSE_OUT_EN = 1'b1;
      end
      S_REQUEST: begin
        CLK_MOUSE_OUT_EN  = (cnt_q == '0);
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = 1'b0;
      end
      S_DATA: begin
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = byte_q[bit_q];
      end
      S_PARITY: begin
        DATA_MOUSE_OUT_EN = 1'b1;
        DATA_MOUSE_OUT    = par_q;
      end
      default: ;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE);
  assign BYTE_SENT = sent_q;
  assign ERROR     = err_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: open-drain bus plus a PS/2 mouse model.
// Scaled timing parameters keep the run short.
module tb_mouse_transmitter;

  localparam int INH = 100;
  localparam int TO  = 1500;
  localparam int H   = 15;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLK_MOUSE_IN;
  logic       CLK_MOUSE_OUT_EN;
  logic       DATA_MOUSE_IN;
  logic       DATA_MOUSE_OUT;
  logic       DATA_MOUSE_OUT_EN;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BUSY;
  logic       BYTE_SENT;
  logic       ERROR;

  logic m_clk;
  logic m_dat;
  logic clk_line;
  logic data_line;

  assign clk_line      = ~CLK_MOUSE_OUT_EN & m_clk;
  assign data_line     = (DATA_MOUSE_OUT_EN ? DATA_MOUSE_OUT : 1'b1) & m_dat;
  assign CLK_MOUSE_IN  = clk_line;
  assign DATA_MOUSE_IN = data_line;

  mouse_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .CLK_MOUSE_IN     (CLK_MOUSE_IN),
    .CLK_MOUSE_OUT_EN (CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_IN    (DATA_MOUSE_IN),
    .DATA_MOUSE_OUT   (DATA_MOUSE_OUT),
    .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
    .SEND_BYTE        (SEND_BYTE),
    .BYTE_TO_SEND     (BYTE_TO_SEND),
    .BUSY             (BUSY),
    .BYTE_SENT        (BYTE_SENT),
    .ERROR            (ERROR)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;
  int sent_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic sent_prev = 1'b0;
  logic err_prev  = 1'b0;

  always @(negedge CLK) begin
    if (BYTE_SENT) sent_cnt++;
    if (ERROR) err_cnt++;
    if (BYTE_SENT && ERROR) both_cnt++;
    if ((BYTE_SENT && sent_prev) || (ERROR && err_prev)) wide_cnt++;
    sent_prev = BYTE_SENT;
    err_prev  = ERROR;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    SEND_BYTE    = 1'b1;
    BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = ~b;
    chk("busy_after_req", 32'(BUSY), 32'd1);
  endtask

  // Counts cycles the clock line is held low by the host.
  task automatic inhibit_len(output int n);
    n = 0;
    while (CLK_MOUSE_OUT_EN && n < 5000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic mouse(input logic ack_low, input int nedges,
                       output logic [9:0] fr);
    int w;
    fr = '1;
    w  = 0;
    while (!(clk_line && !data_line) && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    chk("start_seen", 32'(w < 2000), 32'd1);
    for (int k = 0; k < nedges; k++) begin
      if (k == 10) m_dat = ack_low ? 1'b0 : 1'b1;
      repeat (H) @(negedge CLK);
      m_clk = 1'b0;
      repeat (H) @(negedge CLK);
      if (k < 10) fr[k] = data_line;
      m_clk = 1'b1;
    end
    repeat (H) @(negedge CLK);
    m_dat = 1'b1;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (BUSY && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    chk("done_in_time", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_transfer(input logic [7:0] b, input logic ack_low,
                              output logic [9:0] fr);
    int inh;
    send(b);
    inhibit_len(inh);
    chk("inhibit_len", 32'(inh), 32'(INH + 1));
    chk("start_bit", {30'd0, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT}, 32'd2);
    mouse(ack_low, 11, fr);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ack_low;
    logic [9:0] frame;
    logic       sent;
  } vec_t;

  vec_t       vecs[5];
  logic [9:0] fr;
  int         s0;
  int         e0;
  int         n;

  initial begin
    // frame = {stop, parity, data[7:0]} as seen on the line
    vecs[0] = '{8'hF4, 1'b1, 10'h2F4, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 10'h3FF, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 10'h300, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 10'h201, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 10'h3A5, 1'b1};

    RESET        = 1'b1;
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = 8'h00;
    m_clk        = 1'b1;
    m_dat        = 1'b1;
    #1;
    chk("reset_outs",
        {26'd0, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT,
         BUSY, BYTE_SENT, ERROR}, 32'b001000);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 5; i++) begin
      s0 = sent_cnt;
      e0 = err_cnt;
      run_transfer(vecs[i].b, vecs[i].ack_low, fr);
      wait_done();
      chk($sformatf("frame_%0h", vecs[i].b), 32'(fr), 32'(vecs[i].frame));
      chk("sent_pulse", 32'(sent_cnt - s0), 32'(vecs[i].sent));
      chk("err_pulse", 32'(err_cnt - e0), 32'(!vecs[i].sent));
      chk("idle_lines", {30'd0, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}, 32'd0);
    end

    // Mouse never clocks: timeout counted from clock release.
    s0 = sent_cnt;
    e0 = err_cnt;
    send(8'h3C);
    inhibit_len(n);
    n = 0;
    while (!ERROR && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("timeout_len", 32'(n), 32'(TO));
    chk("timeout_release",
        {29'd0, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, BUSY}, 32'd0);
    repeat (3) @(negedge CLK);
    chk("timeout_no_sent", 32'(sent_cnt - s0), 32'd0);
    chk("timeout_err", 32'(err_cnt - e0), 32'd1);

    // Second request mid-transfer must be ignored.
    s0 = sent_cnt;
    fork
      run_transfer(8'hF4, 1'b1, fr);
      begin
        repeat (250) @(negedge CLK);
        chk("busy_mid", 32'(BUSY), 32'd1);
        SEND_BYTE    = 1'b1;
        BYTE_TO_SEND = 8'h00;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
      end
    join
    wait_done();
    chk("ignored_frame", 32'(fr), 32'h2F4);
    chk("ignored_sent", 32'(sent_cnt - s0), 32'd1);
    repeat (200) @(negedge CLK);
    chk("no_second_tx", {30'd0, BUSY, CLK_MOUSE_OUT_EN}, 32'd0);

    // Reset after the 4th data bit, then a clean transfer.
    s0 = sent_cnt;
    e0 = err_cnt;
    send(8'hF4);
    inhibit_len(n);
    mouse(1'b1, 4, fr);
    chk("partial_bits", 32'(fr[3:0]), 32'h4);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("reset_mid_outs",
        {26'd0, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT,
         BUSY, BYTE_SENT, ERROR}, 32'b001000);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);
    chk("reset_no_pulse", 32'((sent_cnt - s0) + (err_cnt - e0)), 32'd0);
    run_transfer(8'hF5, 1'b1, fr);
    wait_done();
    chk("frame_f5", 32'(fr), 32'h3F5);
    chk("f5_sent", 32'(sent_cnt - s0), 32'd1);
    chk("f5_no_err", 32'(err_cnt - e0), 32'd0);

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("one_cycle_pulses", 32'(wide_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mouse_transmitter.md
MOUSE_TRANSMITTER -- requirements
Module: mouse_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, giving the clock-low inhibit length in CLK cycles (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, giving the maximum CLK cycles allowed in any single non-IDLE state (20 ms).
REQ-003 SHALL have port CLK  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CLK_MOUSE_IN  input  1  sampled level of the PS/2 clock line.
REQ-006 SHALL have port CLK_MOUSE_OUT_EN  output  1  1 = drive the PS/2 clock line low; 0 = release it.
REQ-007 SHALL have port DATA_MOUSE_IN  input  1  sampled level of the PS/2 data line.
REQ-008 SHALL have port DATA_MOUSE_OUT  output  1  value driven on the data line when enabled.
REQ-009 SHALL have port DATA_MOUSE_OUT_EN  output  1  1 = drive DATA_MOUSE_OUT onto the data line; 0 = release it.
REQ-010 SHALL have port SEND_BYTE  input  1  single-cycle request to transmit BYTE_TO_SEND.
REQ-011 SHALL have port BYTE_TO_SEND  input  8  host-to-mouse command byte.
REQ-012 SHALL have port BUSY  output  1  high from request acceptance until the FSM returns to IDLE.
REQ-013 SHALL have port BYTE_SENT  output  1  one-cycle pulse on a successful, acknowledged transfer.
REQ-014 SHALL have port ERROR  output  1  one-cycle pulse on a timeout or NACK.

Function
REQ-015 SHALL synchronise CLK_MOUSE_IN and DATA_MOUSE_IN through two flops each; a falling edge means the synchronised clock was 1 in the previous cycle and is 0 in the current cycle.
REQ-016 SHALL accept SEND_BYTE only in IDLE, latch BYTE_TO_SEND that cycle, assert BUSY the next cycle, and ignore SEND_BYTE while BUSY.
REQ-017 SHALL compute an odd-parity bit at latch time: parity = NOT(XOR of the 8 bits).
REQ-018 SHALL implement the state sequence IDLE -> INHIBIT -> REQUEST -> DATA -> PARITY -> STOP -> ACK -> RELEASE -> IDLE.
REQ-019 INHIBIT: CLK_MOUSE_OUT_EN=1 and DATA_MOUSE_OUT_EN=0 for exactly INHIBIT_CYCLES cycles, then go to REQUEST.
REQ-020 REQUEST: drive the data line low (DATA_MOUSE_OUT_EN=1, DATA_MOUSE_OUT=0) with CLK_MOUSE_OUT_EN=1 for 1 cycle, then set CLK_MOUSE_OUT_EN=0 while keeping data low, and wait for a falling edge.
REQ-021 DATA: on each falling edge, drive the next latched bit, LSB first; after the 8th bit, the next falling edge drives parity (PARITY state).
REQ-022 STOP: on the falling edge after PARITY, release the data line (DATA_MOUSE_OUT_EN=0).
REQ-023 ACK: on the next falling edge, sample data; 0 -> RELEASE; 1 -> pulse ERROR and go to IDLE.
REQ-024 RELEASE: wait until the synchronised clock and data are both 1, then pulse BYTE_SENT and go to IDLE.
REQ-025 SHALL keep a per-state cycle counter, cleared on every state change; if it reaches TIMEOUT_CYCLES in any state after INHIBIT, SHALL release both lines, pulse ERROR, and go to IDLE.
REQ-026 SHALL never assert BYTE_SENT and ERROR in the same cycle.
REQ-027 SHALL keep CLK_MOUSE_OUT_EN=0 in every state except INHIBIT and the first REQUEST cycle.
REQ-028 IDLE outputs: CLK_MOUSE_OUT_EN=0, DATA_MOUSE_OUT_EN=0, DATA_MOUSE_OUT=1, BUSY=0.

Reset
REQ-029 RESET=1 SHALL immediately force IDLE with CLK_MOUSE_OUT_EN=0, DATA_MOUSE_OUT_EN=0, DATA_MOUSE_OUT=1, BUSY=0, BYTE_SENT=0, ERROR=0, all counters 0 and the sync flops at 1.
REQ-030 Reset mid-transfer SHALL abandon the byte with no BYTE_SENT or ERROR pulse; the first request after reset SHALL transmit normally.

Verification
REQ-031 Send 0xF4; the mouse model clocks 11 falling edges and ACKs -> data bits 0,0,1,0,1,1,1,1, parity 0, stop 1, then BYTE_SENT one cycle, BUSY falls.
REQ-032 Send 0xFF -> parity bit 1; BYTE_SENT one cycle; clock line held low for 10000 cycles beforehand.
REQ-033 Mouse model never clocks -> ERROR pulse 2000000 cycles after REQUEST releases the clock; both lines released; no BYTE_SENT.
REQ-034 Mouse model leaves data high at the ACK edge -> ERROR pulse, FSM returns to IDLE, BUSY=0.
REQ-035 SEND_BYTE pulsed again with 0x00 during transfer of 0xF4 -> ignored; only 0xF4 appears on the line.
REQ-036 RESET asserted after the 4th data bit -> outputs reach their reset values immediately with no pulses; a following send of 0xF5 completes with BYTE_SENT.
